dbg_guv_cmd_tx: RTL and testbench

- Command initiator for the dbg_guv daisy chain.
- Accepts host register-write requests on a handshaked stream and serialises each one onto the chain's command stream. The command stream has no backpressure.
- A normal write is an address flit followed by a data flit. A commit is a single address flit whose register address is all ones.
- Sits between the host/AXI-Lite bridge and the first dbg_guv's cmd_in.

---
 rtl/dbg_guv_pkg.sv | 34 +++
 rtl/dbg_guv_cmd_tx.sv | 104 ++++++++++
 tb/tb_dbg_guv_cmd_tx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_guv_pkg.sv
// Shared dbg_guv chain definitions: register map, commit address and address-flit packing.
// Used by the command initiator and by dbg_guv's command decoder.
package dbg_guv_pkg;

  localparam int REG_ADDR_WIDTH = 4;

  localparam logic [REG_ADDR_WIDTH-1:0] COMMIT_REG_ADDR   = '1;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_DROP_CNT      = 4'd0;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_LOG_CNT       = 4'd1;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_INJ_TDATA     = 4'd2;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_INJ_TVALID    = 4'd3;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_INJ_TLAST     = 4'd4;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_INJ_TKEEP     = 4'd5;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_INJ_TDEST     = 4'd6;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_INJ_TID       = 4'd7;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_KEEP_PAUSING  = 4'd8;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_KEEP_LOGGING  = 4'd9;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_KEEP_DROPPING = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } cmd_tx_state_e;

  // Register address in the low bits, core address above it, zeros elsewhere.
  // Callers truncate the result to their flit width.
  function automatic logic [63:0] pack_addr_flit(input logic [31:0]               core_addr,
                                                 input logic [REG_ADDR_WIDTH-1:0] reg_addr);
    return {28'd0, core_addr, reg_addr};
  endfunction

endpackage

// File: rtl/dbg_guv_cmd_tx.sv
// Serialises host register writes onto the dbg_guv command chain (addr flit, then data flit; commit = addr only).
// Address flit one cycle after accept, data flit the cycle after; cmd_out never stalls, req_TREADY only in IDLE.
module dbg_guv_cmd_tx
  import dbg_guv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int CNT_SIZE       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     req_TDATA,
  input  logic [ADDR_WIDTH-1:0]     req_core_addr,
  input  logic [REG_ADDR_WIDTH-1:0] req_reg_addr,
  input  logic                      req_TVALID,
  output logic                      req_TREADY,
  output logic [DATA_WIDTH-1:0]     cmd_out_TDATA,
  output logic                      cmd_out_TVALID,
  output logic                      busy,
  output logic [CNT_SIZE-1:0]       cmd_cnt
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  cmd_tx_state_e             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [ADDR_WIDTH-1:0]     r_core_addr;
  logic [REG_ADDR_WIDTH-1:0] r_reg_addr;
  logic [DATA_WIDTH-1:0]     r_last;
  logic [3:0]                r_gap_cnt, w_gap_nxt;
  logic [CNT_SIZE-1:0]       r_cmd_cnt;
  logic                      w_commit;
  logic                      w_final;
  logic                      w_accept;
  logic [DATA_WIDTH-1:0]     w_addr_flit;

  assign w_commit    = (r_reg_addr == COMMIT_REG_ADDR);
  assign w_accept    = (r_state == ST_IDLE) && req_TVALID;
  assign w_final     = ((r_state == ST_ADDR) && w_commit) || (r_state == ST_DATA);
  assign w_addr_flit = DATA_WIDTH'(pack_addr_flit(32'(r_core_addr), r_reg_addr));

  // Ready is gated by reset so nothing is accepted while the chain is held in reset.
  assign req_TREADY     = rst && (r_state == ST_IDLE);
  assign busy           = (r_state != ST_IDLE);
  assign cmd_out_TVALID = (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign cmd_cnt        = r_cmd_cnt;

  always_comb begin
    cmd_out_TDATA = r_last;
    case (r_state)
      ST_ADDR: cmd_out_TDATA = w_addr_flit;
      ST_DATA: cmd_out_TDATA = r_data;
      default: cmd_out_TDATA = r_last;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    case (r_state)
      ST_IDLE: if (req_TVALID) w_state_nxt = ST_ADDR;
      ST_ADDR, ST_DATA: begin
        if (!w_final) begin
          w_state_nxt = ST_DATA;
        end else if (GAP_CYCLES > 0) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = GAP_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == 4'd0) w_state_nxt = ST_IDLE;
        else                   w_gap_nxt   = r_gap_cnt - 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_core_addr <= '0;
      r_reg_addr  <= '0;
      r_last      <= '0;
      r_gap_cnt   <= '0;
      r_cmd_cnt   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      if (w_final) r_cmd_cnt <= r_cmd_cnt + 1'b1;
      if (cmd_out_TVALID) r_last <= cmd_out_TDATA;
      if (w_accept) begin
        r_data      <= req_TDATA;
        r_core_addr <= req_core_addr;
        r_reg_addr  <= req_reg_addr;
      end
    end
  end

endmodule

// File: tb/tb_dbg_guv_cmd_tx.sv
// Bench for dbg_guv_cmd_tx: instance a (GAP 0, 4-bit counter), instance b (GAP 2, 16-bit counter).
module tb_dbg_guv_cmd_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_dat = '0, b_dat = '0;
  logic [9:0]  a_core = '0, b_core = '0;
  logic [3:0]  a_reg = '0, b_reg = '0;
  logic        a_vld = 1'b0, b_vld = 1'b0;
  logic        a_rdy, b_rdy, a_ovld, b_ovld, a_busy, b_busy;
  logic [31:0] a_odat, b_odat;
  logic [3:0]  a_cnt;
  logic [15:0] b_cnt;

  dbg_guv_cmd_tx #(.GAP_CYCLES(0), .CNT_SIZE(4)) dut_a (
    .clk(clk), .rst(rst), .req_TDATA(a_dat), .req_core_addr(a_core), .req_reg_addr(a_reg),
    .req_TVALID(a_vld), .req_TREADY(a_rdy), .cmd_out_TDATA(a_odat), .cmd_out_TVALID(a_ovld),
    .busy(a_busy), .cmd_cnt(a_cnt));

  dbg_guv_cmd_tx #(.GAP_CYCLES(2), .CNT_SIZE(16)) dut_b (
    .clk(clk), .rst(rst), .req_TDATA(b_dat), .req_core_addr(b_core), .req_reg_addr(b_reg),
    .req_TVALID(b_vld), .req_TREADY(b_rdy), .cmd_out_TDATA(b_odat), .cmd_out_TVALID(b_ovld),
    .busy(b_busy), .cmd_cnt(b_cnt));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: m_k is the position of the current cycle within a command
  // (0 = idle/ready, 1..len = flits, len+1..len+gap = forced gap).
  int          m_k   [2];
  bit          m_cm  [2];
  logic [31:0] m_af  [2];
  logic [31:0] m_df  [2];
  logic [31:0] m_last[2];
  int          m_cnt [2];
  int          ml;

  function automatic int gapv(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int cntmod(input int d);
    return (d == 0) ? 16 : 65536;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        m_k[d] = 0; m_cm[d] = 0; m_af[d] = 0; m_df[d] = 0; m_last[d] = 0; m_cnt[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        ml = m_cm[d] ? 1 : 2;
        if (m_k[d] == 0) begin
          if ((d == 0) ? a_vld : b_vld) begin
            m_cm[d] = (((d == 0) ? a_reg : b_reg) == 4'hF);
            m_af[d] = 32'((d == 0) ? a_core : b_core) * 16 + 32'((d == 0) ? a_reg : b_reg);
            m_df[d] = (d == 0) ? a_dat : b_dat;
            m_k[d]  = 1;
          end
        end else begin
          if (m_k[d] <= ml) m_last[d] = (m_k[d] == 1) ? m_af[d] : m_df[d];
          if (m_k[d] == ml) m_cnt[d] = (m_cnt[d] + 1) % cntmod(d);
          m_k[d] = (m_k[d] >= ml + gapv(d)) ? 0 : m_k[d] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        logic        ev;
        logic [31:0] ed;
        int          len;
        len = m_cm[d] ? 1 : 2;
        ev  = (m_k[d] >= 1) && (m_k[d] <= len);
        ed  = ev ? ((m_k[d] == 1) ? m_af[d] : m_df[d]) : m_last[d];
        chk((d == 0) ? "a_valid" : "b_valid", (d == 0) ? a_ovld : b_ovld, ev);
        chk((d == 0) ? "a_tdata" : "b_tdata", (d == 0) ? a_odat : b_odat, ed);
        chk((d == 0) ? "a_ready" : "b_ready", (d == 0) ? a_rdy : b_rdy, m_k[d] == 0);
        chk((d == 0) ? "a_busy"  : "b_busy",  (d == 0) ? a_busy : b_busy, m_k[d] != 0);
        chk((d == 0) ? "a_cnt"   : "b_cnt",   (d == 0) ? 64'(a_cnt) : 64'(b_cnt), m_cnt[d]);
      end
    end
  end

  task automatic a_send(input logic [9:0] core, input logic [3:0] ra, input logic [31:0] dat);
    bit ok;
    ok = 0;
    @(negedge clk);
    a_core = core; a_reg = ra; a_dat = dat; a_vld = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (a_rdy) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("a_accept_timeout", ok, 1);
    @(posedge clk);
    #1;
    a_vld = 1'b0; a_dat = 32'h0BAD0BAD; a_core = 10'h2AA; a_reg = 4'h3;
  endtask

  logic [9:0]  bt_core[4];
  logic [3:0]  bt_reg [4];
  logic [31:0] bt_dat [4];
  logic [31:0] exp_fl [7];

  task automatic b_set(input int i);
    b_core = bt_core[i]; b_reg = bt_reg[i]; b_dat = bt_dat[i];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          ok;
    int          idx;
    logic [18:0] pat;
    logic [18:0] exp_pat;
    logic [31:0] fl[$];

    // Reset held: everything quiet, ready gated low.
    @(negedge clk);
    chk("rst_ready", a_rdy, 0);
    chk("rst_valid", a_ovld, 0);
    chk("rst_tdata", a_odat, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_busy", a_busy, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Normal write: core 5, reg 2.
    a_send(10'd5, 4'd2, 32'hDEADBEEF);
    @(negedge clk); chk("wr_addr_vld", a_ovld, 1); chk("wr_addr_flit", a_odat, 32'h00000052);
    @(negedge clk); chk("wr_data_vld", a_ovld, 1); chk("wr_data_flit", a_odat, 32'hDEADBEEF);
    @(negedge clk); chk("wr_idle_vld", a_ovld, 0); chk("wr_idle_rdy", a_rdy, 1);
    chk("wr_cnt", a_cnt, 1); chk("wr_hold", a_odat, 32'hDEADBEEF);

    // Commit: one flit, ready again the following cycle.
    a_send(10'd5, 4'hF, 32'h12345678);
    @(negedge clk); chk("cm_flit_vld", a_ovld, 1); chk("cm_flit", a_odat, 32'h0000005F);
    @(negedge clk); chk("cm_idle_vld", a_ovld, 0); chk("cm_rdy", a_rdy, 1); chk("cm_cnt", a_cnt, 2);

    // Maximum core address.
    a_send(10'd1023, 4'd10, 32'h00000001);
    @(negedge clk); chk("max_addr_flit", a_odat, 32'h00003FFA);
    @(negedge clk); chk("max_data_flit", a_odat, 32'h00000001);
    @(negedge clk); chk("max_cnt", a_cnt, 3);

    // Asynchronous reset during the data flit.
    a_send(10'd3, 4'd1, 32'hA5A5A5A5);
    @(negedge clk);
    @(negedge clk); chk("ar_data_vld", a_ovld, 1);
    #1 rst = 1'b0;
    #1;
    chk("ar_vld_drop", a_ovld, 0);
    chk("ar_busy", a_busy, 0);
    chk("ar_rdy_low", a_rdy, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("ar_rel_rdy", a_rdy, 1); chk("ar_rel_cnt", a_cnt, 0); chk("ar_rel_busy", a_busy, 0);

    // Counter wrap with a 4-bit counter.
    for (int k = 1; k <= 17; k++) begin
      a_send(10'(k), 4'hF, 32'h0);
      @(negedge clk);
      @(negedge clk);
      if (k == 15) chk("wrap_15", a_cnt, 15);
      if (k == 16) chk("wrap_16", a_cnt, 0);
      if (k == 17) chk("wrap_17", a_cnt, 1);
    end

    // Back-to-back with GAP_CYCLES=2 and TVALID held high.
    bt_core = '{10'd1, 10'd2, 10'd1023, 10'd7};
    bt_reg  = '{4'd0, 4'd3, 4'd9, 4'hF};
    bt_dat  = '{32'h11111111, 32'h22222222, 32'hCAFEF00D, 32'h0};
    exp_fl  = '{32'h10, 32'h11111111, 32'h23, 32'h22222222, 32'h3FF9, 32'hCAFEF00D, 32'h7F};
    exp_pat = 19'b1100011000110001000;
    @(negedge clk);
    b_set(0); b_vld = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (b_rdy) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("b2b_first_accept", ok, 1);
    @(posedge clk); #1;
    idx = 1; b_set(1);
    pat = '0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      pat[18-c] = b_ovld;
      if (b_ovld) fl.push_back(b_odat);
      if (b_rdy && b_vld) begin
        @(posedge clk); #1;
        idx++;
        if (idx < 4) b_set(idx);
        else b_vld = 1'b0;
      end
    end
    chk("b2b_valid_pattern", pat, exp_pat);
    chk("b2b_flit_count", fl.size(), 7);
    for (int i = 0; i < 7 && i < fl.size(); i++) chk("b2b_flit", fl[i], exp_fl[i]);
    chk("b2b_cnt", b_cnt, 4);
    chk("b2b_busy_end", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
